// File: rtl/apb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_if
// APB3 bus bundle between the AHB-to-APB bridge (master) and the memory
// completer (slave).
//   Psel, Penable, Pwrite   transfer control from the bridge
//   Paddr                   byte address
//   Pwdata                  write data
//   Prdata                  read data returned by the completer
//   Pready                  transfer complete
//   Pslverr                 error response, meaningful only with Pready
// ---------------------------------------------------------------------------
interface apb_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  Psel;
  logic                  Penable;
  logic                  Pwrite;
  logic [ADDR_WIDTH-1:0] Paddr;
  logic [DATA_WIDTH-1:0] Pwdata;
  logic [DATA_WIDTH-1:0] Prdata;
  logic                  Pready;
  logic                  Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
// APB3 completer backing a word-addressed RAM with a programmable number of
// wait states. Unmapped or misaligned accesses complete with Pslverr.
// Ports:
//   Pclk      clock, all state changes on the rising edge
//   Preset    asynchronous active-high reset
//   wait_cfg  wait states inserted per transfer, sampled in the SETUP cycle
//   apb       APB3 slave modport (Psel/Penable/Pwrite/Paddr/Pwdata in,
//             Prdata/Pready/Pslverr out)
// DATA_WIDTH must be at least 16 so a word spans more than one byte.
// ---------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MEM_DEPTH  = 256,
  parameter int                    WS_WIDTH   = 4
) (
  input  logic                Pclk,
  input  logic                Preset,
  input  logic [WS_WIDTH-1:0] wait_cfg,
  apb_mem_slave_if.slave      apb
);

  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(WORD_BYTES);
  localparam int IDX_W      = $clog2(MEM_DEPTH);

  // One extra bit so the upper bound cannot wrap at the top of the map.
  localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_ADDR = LO_ADDR + (ADDR_WIDTH+1)'(MEM_DEPTH * WORD_BYTES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [WS_WIDTH-1:0]   cnt;
  logic                  write_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic setup_take;
  logic ready;
  logic commit;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] ax;
    ax = {1'b0, a};
    return (ax < LO_ADDR) || (ax >= HI_ADDR) || (a[BYTE_SHIFT-1:0] != '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> BYTE_SHIFT);
  endfunction

  // SETUP is only recognised from IDLE; a stray Penable=1 there is ignored.
  assign setup_take = (state == IDLE) && apb.Psel && !apb.Penable;
  assign ready      = (state == ACCESS) && (cnt == '0);
  // Gated by Psel so a transfer dropped by the bridge never writes.
  assign commit     = ready && apb.Psel && write_q && !err_q;

  // ---- control FSM ----
  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (setup_take) begin
            state   <= ACCESS;
            cnt     <= wait_cfg;
            write_q <= apb.Pwrite;
            err_q   <= addr_err(apb.Paddr);
          end
        end
        ACCESS: begin
          if (!apb.Psel) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- latched data path and RAM (not reset) ----
  always_ff @(posedge Pclk) begin
    if (setup_take) begin
      idx_q   <= word_index(apb.Paddr);
      wdata_q <= apb.Pwdata;
    end
    if (commit) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign apb.Pready  = ready;
  assign apb.Pslverr = ready && err_q;
  assign apb.Prdata  = (ready && !err_q && !write_q) ? mem[idx_q] : '0;

endmodule
